// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared helpers for the parameterised synchronous FIFO: ceiling
//            log2 and a parameter-legality predicate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  // Ceiling log2; returns at least 1 so a 2-entry FIFO still gets a 1-bit pointer.
  function automatic int fifo_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  function automatic bit fifo_is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit fifo_params_ok(
    input int data_width,
    input int depth,
    input int ae_level,
    input int af_level
  );
    return (data_width >= 1) &&
           (depth >= 2) &&
           fifo_is_pow2(depth) &&
           (ae_level >= 0) &&
           (ae_level < af_level) &&
           (af_level <= depth);
  endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module   : fifo_mem
// Brief    : DEPTH x DATA_WIDTH storage, one synchronous write port and one
//            asynchronous read port. Contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [fifo_clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [fifo_clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]          o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem

`default_nettype wire

// File: rtl/param_sync_fifo.sv
// ============================================================================
// Module   : param_sync_fifo
// Brief    : Single-clock FIFO with registered status flags, sticky error
//            flags and a selectable standard / first-word-fall-through read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [fifo_clog2(DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = fifo_clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);
  localparam logic [CW-1:0] c_af_lvl   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_ae_lvl   = CW'(AE_LEVEL);

  if (!fifo_params_ok(DATA_WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_param_check
    $error("param_sync_fifo: illegal DATA_WIDTH/DEPTH/AE_LEVEL/AF_LEVEL combination");
  end

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CW-1:0]         w_count_nxt;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Reset wins over both requests, so neither side may touch memory or pointers.
  assign w_wr_acc = wr_en && !r_full  && !rst;
  assign w_rd_acc = rd_en && !r_empty && !rst;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      // Flags come from the next count so they line up with r_count every cycle.
      r_full  <= (w_count_nxt == c_full_cnt);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= c_af_lvl);
      r_ae    <= (w_count_nxt <= c_ae_lvl);
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end
      if (rd_en && r_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is shown combinationally; forced to zero while empty.
    assign dout       = r_empty ? '0 : w_rdata;
    assign dout_valid = !r_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dout       <= '0;
        r_dout_valid <= 1'b0;
      end else begin
        r_dout_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_dout <= w_rdata;
        end
      end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule : param_sync_fifo

`default_nettype wire

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries, power of two and >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have ports: wr_en input 1 write request; din input DATA_WIDTH write data.
REQ-009 SHALL have ports: rd_en input 1 read/pop request; dout output DATA_WIDTH read data; dout_valid output 1 dout qualifier.
REQ-010 SHALL have ports: full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-011 SHALL have port: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have ports: overflow, underflow  output  1 each  sticky error flags.

Function
REQ-013 Write SHALL be accepted iff wr_en && !full; din stored at wr_ptr and wr_ptr advanced at the same edge.
REQ-014 Read SHALL be accepted iff rd_en && !empty; rd_ptr advanced at that edge.
REQ-015 Pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 by natural overflow.
REQ-016 count SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both-accepted or neither.
REQ-017 Flags SHALL be registered, derived from next-state count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-018 Write-to-empty latency: empty SHALL deassert on the edge after the accepting write edge is observed (i.e. one cycle).
REQ-019 FWFT=0: on an accepted read, dout SHALL load mem[rd_ptr] at that edge and dout_valid SHALL pulse high for exactly one cycle; dout holds its value otherwise.
REQ-020 FWFT=1: dout SHALL present mem[rd_ptr] whenever !empty, dout_valid SHALL equal !empty, rd_en pops the presented word.
REQ-021 Full with wr_en && rd_en: read SHALL be accepted, write rejected, overflow set, count becomes DEPTH-1.
REQ-022 Empty with wr_en && rd_en: write SHALL be accepted, read rejected, underflow set, count becomes 1.
REQ-023 overflow SHALL set on any cycle with wr_en && full; underflow on any cycle with rd_en && empty; both held until reset.
REQ-024 Rejected operations SHALL not modify memory, pointers or count.

Reset
REQ-025 rst SHALL dominate wr_en/rd_en in the same cycle.
REQ-026 On rst: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0, dout_valid=0.
REQ-027 Memory contents SHALL not be reset; reset mid-operation discards all stored words logically.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the clog2 helper and parameter-legality checks (DEPTH power of two, AE_LEVEL<AF_LEVEL<=DEPTH).
REQ-029 Storage SHALL be sub-module fifo_mem: DEPTH x DATA_WIDTH array, one synchronous write port, one asynchronous read port, no reset.
REQ-030 Pointer, count, flag and output logic SHALL reside in param_sync_fifo.

Verification
REQ-031 Fill: DEPTH=16, write 0x00..0x0F -> full=1 after 16th write, almost_full=1 at count 14, count=16.
REQ-032 Drain FWFT=0: read 16 after fill -> dout 0x00..0x0F in order, one dout_valid pulse each, empty=1 at end.
REQ-033 Wrap: write 10, read 10, write 12, read 12 -> data order preserved across pointer wrap, count returns to 0.
REQ-034 Boundaries: full + wr_en&rd_en -> count 15, overflow=1; empty + wr_en&rd_en -> count 1, underflow=1.
REQ-035 FWFT=1: single write 0xA5 -> dout=0xA5 and dout_valid=1 one cycle later without rd_en; rd_en pops, empty=1.
REQ-036 Reset mid-operation: count=7, assert rst with wr_en=1 -> next cycle count=0, empty=1, errors cleared, no write stored.
